// File: rtl/playseq_jogador_pkg.sv
// Shared types and constants for the PlaySeq automatic player.
// The optional feature macro PLAYSEQ_JOGADOR_INJETA_ERRO_EN is consumed by the top.
package playseq_jogador_pkg;

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned BTN_W   = 4;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        FILTRA    = 4'd2,
        ACESO     = 4'd3,
        APAGADO   = 4'd4,
        PRESSIONA = 4'd5,
        SOLTA     = 4'd6,
        GUARDA    = 4'd7,
        ERRO      = 4'd8
    } estado_t;

    // True when exactly one bit of the pattern is set
    function automatic logic eh_one_hot(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/playseq_temporizador.sv
// Saturating up-counter; fim flags that the count equals limite.
module playseq_temporizador
    import playseq_jogador_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] valor_q, valor_d;

    // Next count: clear has priority, counting stops at all-ones
    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta && (valor_q != '1)) begin
            valor_d = valor_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign fim = (valor_q == limite);

endmodule

// File: rtl/playseq_jogador_auto.sv
// PlaySeq automatic player: records the LED preview, then replays it on botoes.
// Optional macro PLAYSEQ_JOGADOR_INJETA_ERRO_EN adds injeta_erro, which corrupts
// the last press of a replay (pattern rotated left by one).
module playseq_jogador_auto
    import playseq_jogador_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MIN_ON       = 4,
    parameter int unsigned IDLE_END     = 2000,
    parameter int unsigned PRESS_CYCLES = 100,
    parameter int unsigned GAP_CYCLES   = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             habilita,
`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
    input  logic             injeta_erro,
`endif
    input  logic [BTN_W-1:0] leds,
    output logic [BTN_W-1:0] botoes,
    output logic             jogando,
    output logic             erro,
    output logic [LEN_W-1:0] db_tamanho,
    output logic [3:0]       db_estado
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    estado_t            state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [BTN_W-1:0]   cand_q, cand_d;
    logic [BTN_W-1:0]   botoes_q, botoes_d;
    logic               jogando_q, jogando_d;
    logic               erro_q, erro_d;
    logic               wr_en;
    logic [BTN_W-1:0]   buf_q [DEPTH];
    logic [BTN_W-1:0]   btn_rd;
    logic               ultimo;
    logic               tmr_zera, tmr_fim;
    logic [TIMER_W-1:0] tmr_limite;

    assign btn_rd = buf_q[idx_q[AW-1:0]];
    assign ultimo = (idx_q == len_q - 1'b1);

    // One timer serves every timed state; it restarts on each state change
    assign tmr_zera = (state_d != state_q) || (state_q == INICIAL);

    // Timer limit selected by the state currently being timed
    always_comb begin
        case (state_q)
            FILTRA:    tmr_limite = TIMER_W'(MIN_ON - 1);
            APAGADO:   tmr_limite = TIMER_W'(IDLE_END - 1);
            PRESSIONA: tmr_limite = TIMER_W'(PRESS_CYCLES - 1);
            SOLTA:     tmr_limite = TIMER_W'(GAP_CYCLES - 1);
            default:   tmr_limite = '0;
        endcase
    end

    playseq_temporizador #(.W(TIMER_W)) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .zera   (tmr_zera),
        .conta  (1'b1),
        .limite (tmr_limite),
        .fim    (tmr_fim)
    );

    // Next state plus capture/replay bookkeeping
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cand_d  = cand_q;
        wr_en   = 1'b0;
        if (state_q == INICIAL) begin
            len_d = '0;
        end
        if (!habilita) begin
            state_d = INICIAL;
        end else begin
            case (state_q)
                INICIAL: state_d = ESPERA;
                ESPERA: begin
                    if (leds != '0) begin
                        cand_d  = leds;
                        state_d = FILTRA;
                    end
                end
                FILTRA: begin
                    if (leds != cand_q) begin
                        state_d = ESPERA;
                    end else if (tmr_fim) begin
                        state_d = eh_one_hot(cand_q) ? ACESO : ERRO;
                    end
                end
                ACESO: begin
                    if (leds == '0) begin
                        if (len_q == LEN_W'(DEPTH)) begin
                            state_d = ERRO;
                        end else begin
                            wr_en   = 1'b1;
                            len_d   = len_q + 1'b1;
                            state_d = APAGADO;
                        end
                    end
                end
                APAGADO: begin
                    if (leds != '0) begin
                        cand_d  = leds;
                        state_d = FILTRA;
                    end else if (tmr_fim) begin
                        idx_d   = '0;
                        state_d = PRESSIONA;
                    end
                end
                PRESSIONA: if (tmr_fim) state_d = SOLTA;
                SOLTA: begin
                    if (tmr_fim) begin
                        if (ultimo) begin
                            state_d = GUARDA;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = PRESSIONA;
                        end
                    end
                end
                GUARDA: begin
                    len_d   = '0;
                    state_d = ESPERA;
                end
                ERRO:    state_d = ERRO;
                default: state_d = INICIAL;
            endcase
        end
    end

`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
    logic inj_q, inj_d;

    // Latch the corruption request when the final press begins
    always_comb begin
        inj_d = inj_q;
        if ((state_d == PRESSIONA) && (state_q != PRESSIONA)) begin
            inj_d = injeta_erro && (idx_d == len_q - 1'b1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`endif

    // Output decode from the current state; registered below
    always_comb begin
        botoes_d  = '0;
        jogando_d = 1'b0;
        erro_d    = 1'b0;
        if (habilita) begin
            case (state_q)
                PRESSIONA: begin
                    botoes_d  = btn_rd;
`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
                    if (inj_q && ultimo) begin
                        botoes_d = {btn_rd[BTN_W-2:0], btn_rd[BTN_W-1]};
                    end
`endif
                    jogando_d = 1'b1;
                end
                SOLTA:   jogando_d = 1'b1;
                ERRO:    erro_d    = 1'b1;
                default: ;
            endcase
        end
    end

    // State, counters and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INICIAL;
            len_q     <= '0;
            idx_q     <= '0;
            cand_q    <= '0;
            botoes_q  <= '0;
            jogando_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cand_q    <= cand_d;
            botoes_q  <= botoes_d;
            jogando_q <= jogando_d;
            erro_q    <= erro_d;
        end
    end

    // Sequence buffer; contents are meaningless until written
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[len_q[AW-1:0]] <= cand_q;
        end
    end

    assign botoes     = botoes_q;
    assign jogando    = jogando_q;
    assign erro       = erro_q;
    assign db_tamanho = len_q;
    assign db_estado  = state_q;

endmodule

// File: tb/tb_playseq_jogador_auto.sv
// Bench for playseq_jogador_auto: sequence-level reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_playseq_jogador_auto;

    localparam int DEPTH    = 4;
    localparam int MIN_ON   = 2;
    localparam int IDLE_END = 10;
    localparam int PRESS    = 3;
    localparam int GAP      = 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       habilita = 1'b0;
    logic [3:0] leds     = 4'd0;
`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
    logic       injeta_erro = 1'b0;
`endif
    logic [3:0] botoes;
    logic       jogando;
    logic       erro;
    logic [4:0] db_tamanho;
    logic [3:0] db_estado;

    int vectors     = 0;
    int miscompares = 0;

    playseq_jogador_auto #(
        .DEPTH        (DEPTH),
        .MIN_ON       (MIN_ON),
        .IDLE_END     (IDLE_END),
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
        .injeta_erro (injeta_erro),
`endif
        .leds        (leds),
        .botoes      (botoes),
        .jogando     (jogando),
        .erro        (erro),
        .db_tamanho  (db_tamanho),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // mode: 0 disabled, 1 capturing, 2 replaying, 3 error
    typedef struct {
        logic [3:0] btn;
        logic       jog;
        logic       clr;
    } slot_t;

    slot_t      sched[$];
    logic [3:0] items[$];
    int         mode  = 0;
    int         filt  = -1;
    logic [3:0] cand  = 4'd0;
    bit         lit   = 1'b0;
    bit         armed = 1'b0;
    int         dark  = 0;
    logic [3:0] e_btn = 4'd0;
    logic       e_jog = 1'b0;
    logic       e_err = 1'b0;
    int         e_len = 0;

    task cap_clear();
        filt  = -1;
        lit   = 1'b0;
        armed = 1'b0;
        dark  = 0;
    endtask

    task build_sched();
        slot_t s;
        logic [3:0] v;
        sched.delete();
        for (int i = 0; i < items.size(); i++) begin
            v = items[i];
`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
            if (injeta_erro && (i == items.size() - 1)) v = ((v << 1) | (v >> 3)) & 4'hF;
`endif
            for (int k = 0; k < PRESS; k++) begin
                s.btn = v; s.jog = 1'b1; s.clr = 1'b0; sched.push_back(s);
            end
            for (int k = 0; k < GAP; k++) begin
                s.btn = 4'd0; s.jog = 1'b1; s.clr = 1'b0; sched.push_back(s);
            end
        end
        s.btn = 4'd0; s.jog = 1'b0; s.clr = 1'b1;
        sched.push_back(s);
    endtask

    task capture(input logic [3:0] s);
        if (lit) begin
            if (s == 4'd0) begin
                if (items.size() == DEPTH) mode = 3;
                else begin
                    items.push_back(cand);
                    armed = 1'b1;
                    dark  = 0;
                end
                lit = 1'b0;
            end
        end else if (filt >= 0) begin
            if (s != cand) begin
                filt  = -1;
                armed = 1'b0;
            end else begin
                filt++;
                if (filt == MIN_ON) begin
                    filt = -1;
                    if ($countones(cand) != 1) mode = 3;
                    else lit = 1'b1;
                end
            end
        end else if (s != 4'd0) begin
            cand = s;
            filt = 0;
        end else if (armed) begin
            dark++;
            if (dark == IDLE_END) begin
                mode = 2;
                build_sched();
            end
        end
    endtask

    task model_step();
        slot_t s;
        int pre;
        pre   = mode;
        e_btn = 4'd0;
        e_jog = 1'b0;
        e_err = 1'b0;
        if (pre == 0) items.delete();
        if (!habilita) begin
            mode = 0;
            sched.delete();
        end else begin
            case (pre)
                0: begin mode = 1; cap_clear(); end
                1: capture(leds);
                2: begin
                    s = sched.pop_front();
                    e_btn = s.btn;
                    e_jog = s.jog;
                    if (s.clr) begin
                        items.delete();
                        mode = 1;
                        cap_clear();
                    end
                end
                default: e_err = 1'b1;
            endcase
        end
        e_len = items.size();
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode = 0;
            items.delete();
            sched.delete();
            cap_clear();
            e_btn = 4'd0;
            e_jog = 1'b0;
            e_err = 1'b0;
            e_len = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("botoes", int'(botoes), int'(e_btn));
        chk("jogando", int'(jogando), int'(e_jog));
        chk("erro", int'(erro), int'(e_err));
        chk("db_tamanho", int'(db_tamanho), e_len);
    endtask

    task automatic step(input logic [3:0] l);
        leds = l;
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] tr1 [22];
        logic [3:0] items4 [5];
        logic [3:0] presses[$];
        bit found;
        tr1 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0};
        items4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset state
        habilita = 1'b1;
        step(4'd0);
        step(4'd0);
        chk("reset_estado", int'(db_estado), 0);
        chk("reset_botoes", int'(botoes), 0);
        chk("reset_tamanho", int'(db_tamanho), 0);
        reset = 1'b1;
        step(4'd0);
        chk("espera_estado", int'(db_estado), 1);

        // basic replay of two items
        repeat (5) step(4'b0001);
        repeat (3) step(4'b0000);
        repeat (5) step(4'b0100);
        for (int i = 0; i < 22; i++) begin
            step(4'd0);
            chk("t1_botoes", int'(botoes), int'(tr1[i]));
            if (i == 10) chk("t1_estado_pressiona", int'(db_estado), 5);
            if (i == 11) begin
                chk("t1_tamanho_replay", int'(db_tamanho), 2);
                chk("t1_jogando", int'(jogando), 1);
            end
        end
        chk("t1_estado_final", int'(db_estado), 1);
        chk("t1_tamanho_final", int'(db_tamanho), 0);

        // glitch filter
        step(4'b0010);
        step(4'd0);
        step(4'd0);
        chk("t2_estado", int'(db_estado), 1);
        chk("t2_tamanho", int'(db_tamanho), 0);

        // invalid pattern
        repeat (3) step(4'b0011);
        chk("t3_estado_erro", int'(db_estado), 8);
        step(4'd0);
        chk("t3_erro", int'(erro), 1);
        chk("t3_botoes", int'(botoes), 0);
        habilita = 1'b0;
        step(4'd0);
        chk("t3_estado_inicial", int'(db_estado), 0);
        chk("t3_erro_limpo", int'(erro), 0);
        habilita = 1'b1;
        step(4'd0);
        chk("t3_estado_espera", int'(db_estado), 1);

        // overflow on the fifth item
        for (int k = 0; k < 5; k++) begin
            repeat (4) step(items4[k]);
            step(4'd0);
            if (k < 4) step(4'd0);
        end
        chk("t4_estado", int'(db_estado), 8);
        chk("t4_tamanho", int'(db_tamanho), 4);
        step(4'd0);
        chk("t4_erro", int'(erro), 1);
        habilita = 1'b0;
        step(4'd0);
        habilita = 1'b1;
        step(4'd0);
        chk("t4_tamanho_limpo", int'(db_tamanho), 0);

        // asynchronous reset during a press
        repeat (4) step(4'b1000);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(4'd0);
            if (botoes == 4'b1000) found = 1'b1;
        end
        chk("t5_press_seen", int'(found), 1);
        #1 reset = 1'b0;
        #1;
        chk("t5_botoes", int'(botoes), 0);
        chk("t5_jogando", int'(jogando), 0);
        chk("t5_estado", int'(db_estado), 0);
        step(4'd0);
        reset = 1'b1;
        step(4'd0);
        chk("t5_estado_pos", int'(db_estado), 1);

`ifdef PLAYSEQ_JOGADOR_INJETA_ERRO_EN
        // corrupted final press
        injeta_erro = 1'b1;
        repeat (4) step(4'b0001);
        repeat (2) step(4'b0000);
        repeat (4) step(4'b0010);
        for (int i = 0; i < 40; i++) begin
            step(4'd0);
            if (botoes != 4'd0 && (presses.size() == 0 || presses[presses.size()-1] != botoes))
                presses.push_back(botoes);
        end
        chk("t6_press_count", presses.size(), 2);
        if (presses.size() >= 2) begin
            chk("t6_press0", int'(presses[0]), 1);
            chk("t6_press1", int'(presses[1]), 4);
        end
        injeta_erro = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/playseq_jogador_auto.md
Name: playseq_jogador_auto

Overview:
- Automatic player for PlaySeq; sits at the far end of the game's leds/botoes interface and drives it from a bench or board wrapper.
- Watches `leds` during the game's preview phase and records each one-hot pattern into an internal sequence buffer.
- When the LEDs stay dark long enough, replays the recorded sequence on `botoes` with programmable press/release timing.
- Lets the team exercise ganhou/perdeu/timeout paths without a human player.

Parameters:
- DEPTH, 16: max stored jogadas; power of 2, at most 16.
- MIN_ON, 4: cycles `leds` must hold a stable nonzero value to count as one item (glitch filter).
- IDLE_END, 2000: consecutive dark cycles after at least one item that end capture.
- PRESS_CYCLES, 100: cycles each button is held.
- GAP_CYCLES, 100: cycles `botoes` is 0 between presses and after the last press.

Ports:
- clock, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- habilita, input, 1: 0 forces INICIAL and `botoes`=0.
- leds, input, 4: LED outputs of the game.
- botoes, output, 4: registered button drive to the game.
- jogando, output, 1: high in PRESSIONA/SOLTA.
- erro, output, 1: sticky error flag.
- db_tamanho, output, 5: number of items currently stored.
- db_estado, output, 4: FSM state code, feeds hexa7seg.

Behaviour:
- Reset (reset=0, async):
  - state=INICIAL; botoes=0, jogando=0, erro=0; db_tamanho=0.
  - Buffer contents are don't-care.
- Outputs are registered; `botoes` changes one cycle after the state transition that implies it.
- FSM states and codes:
  - INICIAL(0): len:=0, timer cleared. habilita=1 -> ESPERA.
  - ESPERA(1): leds!=0 -> FILTRA, timer:=0, cand:=leds.
  - FILTRA(2): leds!=cand -> ESPERA (glitch). Stable for MIN_ON cycles -> ACESO. If cand is not one-hot -> ERRO.
  - ACESO(3): wait for leds==0. On that cycle: buf[len]:=cand, len:=len+1, timer:=0 -> APAGADO. If len==DEPTH on the store attempt -> ERRO, no write.
  - APAGADO(4): leds!=0 -> FILTRA, cand:=leds, timer:=0. Timer reaching IDLE_END-1 -> PRESSIONA with idx:=0.
  - PRESSIONA(5): botoes=buf[idx] for exactly PRESS_CYCLES cycles -> SOLTA.
  - SOLTA(6): botoes=0 for GAP_CYCLES. Then if idx==len-1 -> GUARDA, else idx:=idx+1 -> PRESSIONA.
  - GUARDA(7): len:=0 -> ESPERA. The next round re-previews the whole, longer sequence.
  - ERRO(8): botoes=0, erro=1. Exit only via habilita=0 or reset.
- `leds` is ignored in PRESSIONA/SOLTA/GUARDA; the game echoes presses on its LEDs.
- habilita=0 in any state -> INICIAL next cycle; botoes=0 that cycle; erro cleared.
- APAGADO is entered only with len>=1. ESPERA never times out.
- `leds` change to a different nonzero value inside ACESO: treated as still lit; the original cand is stored when leds returns to 0.
- Counters: the 16-bit timer saturates (no wrap). idx and len are 5-bit, unsigned.

Optional Feature:
- Macro: PLAYSEQ_JOGADOR_INJETA_ERRO_EN.
- Defined:
  - Adds input `injeta_erro` (1 bit), sampled on entry to PRESSIONA with idx==len-1.
  - If high, the last press drives buf[idx] rotated left by 1 ({b[2:0],b[3]}), forcing a wrong jogada.
- Undefined: port absent; replay is always exact.

Decomposition:
- Package playseq_jogador_pkg:
  - State enum codes 0-8.
  - Widths: TIMER_W=16, LEN_W=5, BTN_W=4.
  - One-hot check function.
- Sub-module playseq_temporizador: parametrized up-counter with ports zera, conta, limite, fim, saturating.
  - One instance is shared by FILTRA/APAGADO/PRESSIONA/SOLTA, with the limit muxed by state.

Test Plan:
Use DEPTH=4, MIN_ON=2, IDLE_END=10, PRESS_CYCLES=3, GAP_CYCLES=2.
1. Basic replay: leds=0001 for 5 cycles, 0 for 3, 0100 for 5, then 0 for 10 -> botoes=0001 for 3 cycles, 0 for 2, 0100 for 3, 0 for 2; db_tamanho=2 during replay, 0 after GUARDA; db_estado returns to 1.
2. Glitch filter: leds=0010 for 1 cycle only -> nothing stored, db_tamanho=0, state stays ESPERA.
3. Invalid pattern: leds=0011 held 3 cycles -> erro=1, state 8, botoes=0; habilita=0 for 1 cycle clears erro, state 0.
4. Overflow: 5 valid one-hot items without a 10-cycle dark gap -> erro=1 on the 5th falling edge; db_tamanho=4.
5. Async reset: reset=0 mid-PRESSIONA with botoes=1000 -> botoes=0, jogando=0, db_estado=0 immediately, without a clock edge.
6. Injected error (macro on): items 0001, 0010; injeta_erro=1 -> second press is 0100.
